// File: rtl/ihp_sram_arb_pkg.sv
// ihp_sram_arb_pkg: shared types and default widths for the IHP SRAM port arbiter
package ihp_sram_arb_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/ihp_sram_rr_arb2.sv
// ihp_sram_rr_arb2: 2-way round-robin arbiter; grants at most one port per cycle
// Ports: UserCLK/resetn clock and async active-low reset; en gates all grants;
// req_a/req_b requests in; gnt_a/gnt_b same-cycle grants out.
module ihp_sram_rr_arb2
  import ihp_sram_arb_pkg::*;
(
  input  logic UserCLK,
  input  logic resetn,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  port_t last_winner;
  always_comb begin
    gnt_a = en && req_a && (!req_b || last_winner == PORT_B);
    gnt_b = en && req_b && !gnt_a;
  end
  always_ff @(posedge UserCLK or negedge resetn)
    if (!resetn) last_winner <= PORT_B;
    else if (gnt_a) last_winner <= PORT_A;
    else if (gnt_b) last_winner <= PORT_B;
endmodule

// File: rtl/ihp_sram_port_arbiter.sv
// ihp_sram_port_arbiter: shares one single-port SRAM macro between two requesters, with zero-fill clear
// Ports: UserCLK/resetn clock and async active-low reset; clear_req/clear_busy/clear_done
// clear control; a_*/b_* req/gnt request ports with rvalid/rdata return; sram_* macro pins.
module ihp_sram_port_arbiter
  import ihp_sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              UserCLK,
  input  logic              resetn,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] a_bm,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [DATA_W-1:0] b_bm,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              sram_men,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_bm,
  input  logic [DATA_W-1:0] sram_dout
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic rd_pending;
  port_t rd_owner;
  logic [DATA_W-1:0] a_hold, b_hold;
  logic last_clear;
  assign last_clear = state == CLEAR && cnt == '1;
  ihp_sram_rr_arb2 u_arb (
    .UserCLK(UserCLK),
    .resetn (resetn),
    .en     (state == IDLE),
    .req_a  (a_req),
    .req_b  (b_req),
    .gnt_a  (a_gnt),
    .gnt_b  (b_gnt)
  );
  always_comb begin
    state_nxt = state == IDLE ? (clear_req ? CLEAR : IDLE) : (last_clear ? IDLE : CLEAR);
    clear_busy = state == CLEAR;
    a_rvalid = rd_pending && rd_owner == PORT_A;
    b_rvalid = rd_pending && rd_owner == PORT_B;
    // sram_dout is only meaningful the cycle after a read, so rdata passes it through then and holds otherwise
    a_rdata = a_rvalid ? sram_dout : a_hold;
    b_rdata = b_rvalid ? sram_dout : b_hold;
    sram_men = clear_busy || a_gnt || b_gnt;
    sram_wen = clear_busy || (a_gnt && a_we) || (b_gnt && b_we);
    sram_ren = (a_gnt && !a_we) || (b_gnt && !b_we);
    sram_addr = clear_busy ? cnt : a_gnt ? a_addr : b_gnt ? b_addr : '0;
    sram_din = clear_busy ? '0 : a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    sram_bm = clear_busy ? '1 : a_gnt ? a_bm : b_gnt ? b_bm : '0;
  end
  always_ff @(posedge UserCLK or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      clear_done <= 1'b0;
      rd_pending <= 1'b0;
      rd_owner <= PORT_A;
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      state <= state_nxt;
      // counter wraps to 0 on the last clear write, so every clear starts at address 0
      if (clear_busy) cnt <= cnt + ADDR_W'(1);
      clear_done <= last_clear;
      rd_pending <= sram_ren;
      rd_owner <= b_gnt ? PORT_B : PORT_A;
      if (a_rvalid) a_hold <= sram_dout;
      if (b_rvalid) b_hold <= sram_dout;
    end
endmodule
